// File: rtl/door_plant_if.sv
// -----------------------------------------------------------------------------
// door_plant_if
// Motor-command / limit-switch bundle between the automatic-door controller
// (master) and the door plant model (slave).
//   UP_M, DN_M     : motor commands, controller -> plant
//   UP_Max, DN_Max : limit switches, plant -> controller
//   Pos            : current door position
//   Moving         : door is being driven and travelling
//   Stall          : a motor is driven against its own limit
//   Fault          : sticky illegal-drive flag (both motors at once)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface door_plant_if #(
    parameter int POS_W = 8
);
    logic             UP_M;
    logic             DN_M;
    logic             UP_Max;
    logic             DN_Max;
    logic [POS_W-1:0] Pos;
    logic             Moving;
    logic             Stall;
    logic             Fault;

    modport master (
        output UP_M, DN_M,
        input  UP_Max, DN_Max, Pos, Moving, Stall, Fault
    );

    modport slave (
        input  UP_M, DN_M,
        output UP_Max, DN_Max, Pos, Moving, Stall, Fault
    );
endinterface

// File: rtl/door_plant.sv
// -----------------------------------------------------------------------------
// door_plant
// Synthesisable model of the door mechanism. It consumes the controller's
// motor commands and produces the limit switches the controller reads, so the
// controller can be exercised closed-loop in simulation or on an FPGA demo.
//
// Position advances one step per STEP_DIV cycles of uninterrupted drive in the
// same direction. Driving both motors at once latches a fault that freezes the
// door until reset.
//
// Ports
//   CLK : system clock, rising edge
//   RST : asynchronous active-low reset
//   bus : door_plant_if.slave (UP_M/DN_M in; UP_Max/DN_Max/Pos/Moving/
//         Stall/Fault out)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module door_plant #(
    parameter int TRAVEL   = 8,   // steps from closed (0) to open (TRAVEL), 2..255
    parameter int STEP_DIV = 4,   // drive cycles per step, 1..255
    parameter int POS_W    = 8    // must hold TRAVEL
) (
    input  logic         CLK,
    input  logic         RST,
    door_plant_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_UP    = 2'd1,
        ST_DN    = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [POS_W-1:0] P_TOP  = POS_W'(TRAVEL);
    localparam logic [7:0]       DIV_TC = 8'(STEP_DIV - 1);

    state_t           r_state;
    state_t           w_next;
    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] w_pos_nxt;
    logic [7:0]       r_div;
    logic [7:0]       w_div_nxt;
    logic             r_fault;
    logic             r_stall;
    logic             w_stall_nxt;

    logic w_up_only;
    logic w_dn_only;
    logic w_both;
    logic w_at_top;
    logic w_at_bot;

    assign w_up_only = bus.UP_M & ~bus.DN_M;
    assign w_dn_only = bus.DN_M & ~bus.UP_M;
    assign w_both    = bus.UP_M &  bus.DN_M;
    assign w_at_top  = (r_pos == P_TOP);
    assign w_at_bot  = (r_pos == '0);

    // -------------------------------------------------------------------------
    // Next-state: illegal drive wins over everything, fault is absorbing.
    // Drive against a limit falls through to IDLE, which is also how a door
    // that has just arrived at a limit stops one edge later.
    // -------------------------------------------------------------------------
    always_comb begin
        w_next = ST_IDLE;
        if (w_both) begin
            w_next = ST_FAULT;
        end else if (r_state == ST_FAULT) begin
            w_next = ST_FAULT;
        end else if (w_up_only && !w_at_top) begin
            w_next = ST_UP;
        end else if (w_dn_only && !w_at_bot) begin
            w_next = ST_DN;
        end
    end

    // -------------------------------------------------------------------------
    // Prescaler and position. The divider only runs while the state is held
    // in the same direction across the edge; any change of state (stop,
    // reversal, fault) leaves the default of zero, discarding partial steps.
    // The limit guards are redundant with the state decode but keep pos
    // saturating even if the state logic is ever loosened.
    // -------------------------------------------------------------------------
    always_comb begin
        w_div_nxt = '0;
        w_pos_nxt = r_pos;
        if (((r_state == ST_UP) || (r_state == ST_DN)) && (w_next == r_state)) begin
            if (r_div == DIV_TC) begin
                w_div_nxt = '0;
                if ((r_state == ST_UP) && !w_at_top) begin
                    w_pos_nxt = r_pos + POS_W'(1);
                end else if ((r_state == ST_DN) && !w_at_bot) begin
                    w_pos_nxt = r_pos - POS_W'(1);
                end
            end else begin
                w_div_nxt = r_div + 8'd1;
            end
        end
    end

    // Stall looks at the position before the edge, so it rises one edge after
    // the door has come to rest against the driven limit. Never set in fault.
    always_comb begin
        w_stall_nxt = 1'b0;
        if (w_next != ST_FAULT) begin
            w_stall_nxt = (w_up_only & w_at_top) | (w_dn_only & w_at_bot);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
            r_pos   <= '0;
            r_div   <= '0;
            r_fault <= 1'b0;
            r_stall <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pos   <= w_pos_nxt;
            r_div   <= w_div_nxt;
            r_fault <= r_fault | w_both;
            r_stall <= w_stall_nxt;
        end
    end

    // Outputs decode from registered state only; no input-to-output paths.
    assign bus.UP_Max = w_at_top;
    assign bus.DN_Max = w_at_bot;
    assign bus.Pos    = r_pos;
    assign bus.Moving = (r_state == ST_UP) || (r_state == ST_DN);
    assign bus.Stall  = r_stall;
    assign bus.Fault  = r_fault;

endmodule

// File: tb/tb_door_plant.sv
`timescale 1ns/1ps

module tb_door_plant;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    always #10 CLK = ~CLK;

    door_plant_if #(.POS_W(8)) dif ();
    door_plant_if #(.POS_W(8)) dif1 ();

    door_plant #(.TRAVEL(8), .STEP_DIV(4), .POS_W(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (dif)
    );

    // Fast-stepping variant: one step per edge, short travel.
    door_plant #(.TRAVEL(3), .STEP_DIV(1), .POS_W(8)) dut1 (
        .CLK (CLK),
        .RST (RST),
        .bus (dif1)
    );

    typedef struct {
        logic       up;
        logic       dn;
        int         cyc;     // edges to run before sampling (0: sample now)
        logic [7:0] pos;
        logic       upmax;
        logic       dnmax;
        logic       mov;
        logic       stall;
        logic       sx;      // 1: stall not checked on this row
        logic       fault;
        string      name;
    } vec_t;

    vec_t tbl[15];
    vec_t sb[$];

    int n_tot  = 0;
    int n_pass = 0;

    function automatic vec_t mk(input logic up, input logic dn, input int cyc,
                                input logic [7:0] pos, input logic mov,
                                input logic stall, input logic sx,
                                input logic fault, input string name);
        vec_t v;
        v.up    = up;
        v.dn    = dn;
        v.cyc   = cyc;
        v.pos   = pos;
        v.upmax = (pos == 8'd8);
        v.dnmax = (pos == 8'd0);
        v.mov   = mov;
        v.stall = stall;
        v.sx    = sx;
        v.fault = fault;
        v.name  = name;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_pop();
        vec_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.name, ".pos"},    dif.Pos,    e.pos);
        chk({e.name, ".upmax"},  dif.UP_Max, e.upmax);
        chk({e.name, ".dnmax"},  dif.DN_Max, e.dnmax);
        chk({e.name, ".moving"}, dif.Moving, e.mov);
        if (!e.sx) chk({e.name, ".stall"}, dif.Stall, e.stall);
        chk({e.name, ".fault"},  dif.Fault,  e.fault);
    endtask

    // Drive inputs, push expected, let cycles elapse, sample 1 ns after edge.
    task automatic run_vec(input vec_t v);
        dif.UP_M = v.up;
        dif.DN_M = v.dn;
        sb.push_back(v);
        if (v.cyc == 0) begin
            #1;
        end else begin
            repeat (v.cyc) @(posedge CLK);
            #1;
        end
        check_pop();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        // Closed -> open -> closed with held drive. k = first edge with UP_M.
        tbl[0]  = mk(0, 0,  2, 8'd0, 0, 0, 0, 0, "idle");
        tbl[1]  = mk(1, 0,  1, 8'd0, 1, 0, 0, 0, "up_k");
        tbl[2]  = mk(1, 0,  3, 8'd0, 1, 0, 0, 0, "up_k3");
        tbl[3]  = mk(1, 0,  1, 8'd1, 1, 0, 0, 0, "up_k4_step");
        tbl[4]  = mk(1, 0, 27, 8'd7, 1, 0, 0, 0, "up_k31");
        tbl[5]  = mk(1, 0,  1, 8'd8, 1, 0, 0, 0, "up_k32_top");
        tbl[6]  = mk(1, 0,  1, 8'd8, 0, 0, 1, 0, "up_k33_stop");
        tbl[7]  = mk(1, 0,  7, 8'd8, 0, 1, 0, 0, "up_stall");
        tbl[8]  = mk(0, 0,  1, 8'd8, 0, 0, 0, 0, "open_idle");
        tbl[9]  = mk(0, 1,  1, 8'd8, 1, 0, 0, 0, "dn_j");
        tbl[10] = mk(0, 1,  4, 8'd7, 1, 0, 0, 0, "dn_j4_step");
        tbl[11] = mk(0, 1, 28, 8'd0, 1, 0, 0, 0, "dn_j32_bot");
        tbl[12] = mk(0, 1,  1, 8'd0, 0, 0, 1, 0, "dn_j33_stop");
        tbl[13] = mk(0, 1,  3, 8'd0, 0, 1, 0, 0, "dn_stall");
        tbl[14] = mk(0, 0,  1, 8'd0, 0, 0, 0, 0, "closed_idle");

        dif.UP_M  = 1'b0;
        dif.DN_M  = 1'b0;
        dif1.UP_M = 1'b0;
        dif1.DN_M = 1'b0;

        // Reset state while RST is still asserted.
        #15;
        run_vec(mk(0, 0, 0, 8'd0, 0, 0, 0, 0, "in_reset"));
        #3 RST = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < 15; i++) run_vec(tbl[i]);

        // Reversal: up 10 edges reaches pos 2, switch edge clears divider.
        run_vec(mk(1, 0, 10, 8'd2, 1, 0, 0, 0, "rev_up10"));
        run_vec(mk(0, 1,  1, 8'd2, 1, 0, 0, 0, "rev_switch"));
        run_vec(mk(0, 1,  3, 8'd2, 1, 0, 0, 0, "rev_sw3"));
        run_vec(mk(0, 1,  1, 8'd1, 1, 0, 0, 0, "rev_sw4_step"));
        run_vec(mk(0, 1,  4, 8'd0, 1, 0, 0, 0, "rev_bot"));
        run_vec(mk(0, 0,  1, 8'd0, 0, 0, 0, 0, "rev_idle"));

        // One-cycle illegal drive at pos 3 latches a permanent freeze.
        run_vec(mk(1, 0, 13, 8'd3, 1, 0, 0, 0, "flt_pos3"));
        run_vec(mk(1, 1,  1, 8'd3, 0, 0, 0, 1, "flt_both"));
        run_vec(mk(1, 0, 10, 8'd3, 0, 0, 0, 1, "flt_up_ign"));
        run_vec(mk(0, 1, 10, 8'd3, 0, 0, 0, 1, "flt_dn_ign"));
        run_vec(mk(0, 0,  2, 8'd3, 0, 0, 0, 1, "flt_hold"));

        // Asynchronous reset between edges clears everything at once.
        #3 RST = 1'b0;
        run_vec(mk(0, 0, 0, 8'd0, 0, 0, 0, 0, "async_rst"));
        #2 RST = 1'b1;
        @(posedge CLK); #1;
        run_vec(mk(0, 0, 1, 8'd0, 0, 0, 0, 0, "post_rst"));

        // STEP_DIV=1, TRAVEL=3: a step on every edge after entry.
        dif1.UP_M = 1'b1;
        @(posedge CLK); #1;
        chk("sd1_k.pos",     dif1.Pos,    8'd0);
        chk("sd1_k.moving",  dif1.Moving, 1'b1);
        @(posedge CLK); #1;
        chk("sd1_k1.pos",    dif1.Pos,    8'd1);
        chk("sd1_k1.dnmax",  dif1.DN_Max, 1'b0);
        @(posedge CLK); #1;
        chk("sd1_k2.pos",    dif1.Pos,    8'd2);
        @(posedge CLK); #1;
        chk("sd1_k3.pos",    dif1.Pos,    8'd3);
        chk("sd1_k3.upmax",  dif1.UP_Max, 1'b1);
        chk("sd1_k3.moving", dif1.Moving, 1'b1);
        @(posedge CLK); #1;
        chk("sd1_k4.moving", dif1.Moving, 1'b0);
        chk("sd1_k4.pos",    dif1.Pos,    8'd3);
        dif1.UP_M = 1'b0;
        @(posedge CLK); #1;

        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/door_plant.md
# door_plant

Behavioural-synthesisable model of the door mechanism driven by the automatic-door controller. Consumes the controller's motor commands (UP_M, DN_M) and produces the limit-switch inputs (UP_Max, DN_Max) that the controller reads, closing the loop for system-level simulation and FPGA demo builds. Tracks door position with a prescaled counter, detects illegal drive combinations and reports motion status.

## Interface
- TRAVEL, 8: position steps from fully closed (0) to fully open (TRAVEL); legal range 2..255
- STEP_DIV, 4: clock cycles of continuous drive per position step; legal range 1..255
- POS_W, 8: width of Pos output; must hold TRAVEL

- CLK  in  1  system clock, all state updates on rising edge
- RST  in  1  asynchronous, active-low reset
- UP_M  in  1  open-motor command from controller
- DN_M  in  1  close-motor command from controller
- UP_Max  out  1  upper limit switch, 1 when Pos == TRAVEL
- DN_Max  out  1  lower limit switch, 1 when Pos == 0
- Pos  out  POS_W  current door position
- Moving  out  1  1 while in ST_UP or ST_DN
- Stall  out  1  1 while a motor is driven against its own limit
- Fault  out  1  sticky; set when UP_M and DN_M are sampled high together

## Operation
- State register: ST_IDLE, ST_UP, ST_DN, ST_FAULT. Internal regs: pos (POS_W), div_cnt (8 bit).
- Reset (RST=0, asynchronous): state=ST_IDLE, pos=0, div_cnt=0, Fault=0. Outputs during/after reset: DN_Max=1, UP_Max=0, Pos=0, Moving=0, Stall=0, Fault=0.
- Transitions, evaluated each edge on sampled UP_M/DN_M, in priority order:
  - any state, UP_M=1 & DN_M=1 -> ST_FAULT, Fault=1
  - ST_FAULT -> stays ST_FAULT until RST; pos frozen, inputs ignored
  - UP_M=1 & DN_M=0 & pos<TRAVEL -> ST_UP
  - DN_M=1 & UP_M=0 & pos>0 -> ST_DN
  - otherwise -> ST_IDLE (includes no drive, or drive against the limit)
- Prescaler: in ST_UP/ST_DN, div_cnt increments each edge; when div_cnt == STEP_DIV-1 and direction unchanged, pos steps ±1 and div_cnt clears. Any state change (stop, reversal, fault, entry to IDLE) clears div_cnt, so partial progress is discarded.
- pos saturates: never exceeds TRAVEL, never goes below 0. Arriving at a limit drops state to ST_IDLE on the next edge.
- UP_Max, DN_Max, Moving decode combinationally from registered pos/state only (no input-to-output paths).
- Stall = registered (UP_M & ~DN_M & pos==TRAVEL) | (DN_M & ~UP_M & pos==0); cleared in ST_FAULT.

## Timing
- Motion start: UP_M rises before edge k -> state=ST_UP after edge k, Moving=1 after edge k.
- First step: Pos increments after edge k+STEP_DIV (div_cnt counts 0..STEP_DIV-1 from entry, step on terminal count).
- Full travel closed->open with constant UP_M: Pos reaches TRAVEL after edge k+TRAVEL*STEP_DIV; DN_Max falls with first step; UP_Max rises same edge Pos reaches TRAVEL; Moving falls one edge later.
- Defaults: 32 cycles full travel (640 ns at 20 ns clock).
- Reversal mid-travel (UP_M->DN_M): one edge to switch state to ST_DN, div_cnt cleared, next step down STEP_DIV edges after the switch edge.
- STEP_DIV=1: pos steps every edge while driven.
- Simultaneous UP_M & DN_M for one cycle only: Fault still latches; motion halts permanently until reset.
- RST assertion mid-travel: immediate return to reset values (Pos=0) regardless of clock.

## Test plan
- Reset with defaults, UP_M=DN_M=0 -> DN_Max=1, UP_Max=0, Pos=0, Moving=0, Fault=0.
- UP_M=1 held 40 cycles from closed -> Pos=1 after 4 edges, DN_Max=0 after edge 4, UP_Max=1 and Pos=8 after edge 32, Moving=0 by edge 33, Stall=1 from edge 34 on.
- From open, DN_M=1 held 40 cycles -> Pos=0 and DN_Max=1 after edge 32, UP_Max=0 after first step (edge 4).
- UP_M=1 for 10 cycles then DN_M=1 -> Pos=2 at switch; switch edge clears div_cnt; Pos=1 four edges after the switch edge; no skipped or double steps.
- UP_M=DN_M=1 for one cycle at Pos=3 -> Fault=1, Moving=0, Pos held at 3 under any later drive; RST low pulse -> Fault=0, Pos=0.
- Closed-loop with auto-door controller, Activate pulse -> door opens to UP_Max=1, second Activate -> closes to DN_Max=1, Fault never asserts.
